load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 39 +++
 rtl/load_store_unit.sv | 185 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// Bus bundle for load_store_unit.
// Groups the core request/response handshake and the memory-side bus.
//   slave  : the load/store unit's view (takes requests, drives memory)
//   master : the environment's view (core issuing requests + memory answering)
// Signals:
//   req_valid/req_ready/req_write/req_funct3/req_addr/req_wdata : core request
//   rsp_valid/rsp_rdata/rsp_error                               : core response
//   mem_req/mem_we/mem_addr/mem_be/mem_wdata                    : memory request
//   mem_ack/mem_rdata                                           : memory completion
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_ack, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
           mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: accepts one load/store at a time from the core,
// issues a single word-aligned memory access with byte enables, and returns
// aligned, sign/zero-extended load data (or an error) as a one-cycle response.
//
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-low
//   bus   : load_store_unit_if.slave (request, response and memory bus)
// Parameter:
//   TIMEOUT_CYCLES : cycles mem_req is held waiting for mem_ack before the
//                    access is abandoned with an error response
// Optional build macro:
//   LSU_MISALIGN_TRAP_EN : misaligned half/word accesses respond with an
//                          error and never reach memory; when undefined the
//                          offending low address bits are cleared instead.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | mem_req held with stable bus fields until mem_ack or timeout
// RESP   | one-cycle rsp_valid pulse, then back to IDLE
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic                  clk,
  input logic                  reset,
  load_store_unit_if.slave     bus
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            state, state_nx;
  logic [31:0]       addr_q;
  logic [2:0]        funct3_q;
  logic              write_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              accept;
  logic              reserved_in;
  logic              trap_in;
  logic              fail_in;
  logic [31:0]       addr_in;
  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       lane;
  logic [31:0]       load_data;

  // Request decode at accept time
  assign accept      = (state == IDLE) && bus.req_valid;
  assign reserved_in = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11);
  assign fail_in     = reserved_in || trap_in;

`ifdef LSU_MISALIGN_TRAP_EN
  always_comb begin
    addr_in = bus.req_addr;
    trap_in = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   trap_in = bus.req_addr[0];
      2'b10:   trap_in = (bus.req_addr[1:0] != 2'b00);
      default: trap_in = 1'b0;
    endcase
  end
`else
  // Misalignment is silently corrected by clearing the low address bits
  always_comb begin
    addr_in = bus.req_addr;
    trap_in = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   addr_in[0]   = 1'b0;
      2'b10:   addr_in[1:0] = 2'b00;
      default: addr_in      = bus.req_addr;
    endcase
  end
`endif

  // Lane steering for the latched access
  always_comb begin
    be        = 4'b1111;
    wdata_rep = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        be        = 4'b0001 << addr_q[1:0];
        wdata_rep = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        be        = addr_q[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata_q[15:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = wdata_q;
      end
    endcase
  end

  // Selected lane shifted down to bit 0, then extended; funct3[2] = unsigned
  always_comb begin
    lane      = bus.mem_rdata >> {addr_q[1:0], 3'b000};
    load_data = lane;
    case (funct3_q[1:0])
      2'b00:   load_data = {{24{~funct3_q[2] & lane[7]}}, lane[7:0]};
      2'b01:   load_data = {{16{~funct3_q[2] & lane[15]}}, lane[15:0]};
      default: load_data = lane;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = '0;
    bus.rsp_error = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_be    = '0;
    bus.mem_wdata = '0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) state_nx = fail_in ? RESP : ACCESS;
      end
      ACCESS: begin
        bus.mem_req   = 1'b1;
        bus.mem_we    = write_q;
        bus.mem_addr  = {addr_q[31:2], 2'b00};
        bus.mem_be    = be;
        bus.mem_wdata = wdata_rep;
        if (bus.mem_ack || (cnt_q == '0)) state_nx = RESP;
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_rdata = rdata_q;
        bus.rsp_error = err_q;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Request latches, timeout down-counter, load data capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      funct3_q <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        addr_q   <= addr_in;
        funct3_q <= bus.req_funct3;
        write_q  <= bus.req_write;
        wdata_q  <= bus.req_wdata;
        err_q    <= fail_in;
        rdata_q  <= '0;
        cnt_q    <= CNT_W'(TIMEOUT_CYCLES - 1);
      end else if (state == ACCESS) begin
        // An ack on the terminal-count cycle still completes normally
        if (bus.mem_ack) begin
          if (!write_q) rdata_q <= load_data;
        end else if (cnt_q == '0) begin
          err_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  load_store_unit_if bus();

  load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_delay;
    logic        exp_access;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic write, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_valid  = 1'b1;
    bus.req_write  = write;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   mem_cycles;
    int   rsp_cyc;
    logic got_rsp;
    logic [31:0] rd;
    logic err;
    mem_cycles = 0;
    rsp_cyc    = 0;
    got_rsp    = 1'b0;
    rd         = '0;
    err        = 1'b0;
    @(negedge clk);
    check($sformatf("v%0d req_ready", idx), 32'(bus.req_ready), 32'd1);
    drive_req(v.write, v.funct3, v.addr, v.wdata);
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.mem_req) begin
        check($sformatf("v%0d mem_addr", idx), bus.mem_addr, v.exp_addr);
        check($sformatf("v%0d mem_be", idx), 32'(bus.mem_be), 32'(v.exp_be));
        check($sformatf("v%0d mem_we", idx), 32'(bus.mem_we), 32'(v.write));
        if (v.write) check($sformatf("v%0d mem_wdata", idx), bus.mem_wdata, v.exp_wdata);
        bus.mem_ack   = (mem_cycles == v.ack_delay);
        bus.mem_rdata = v.rdata;
        mem_cycles++;
      end else begin
        bus.mem_ack = 1'b0;
      end
      if (bus.rsp_valid) begin
        got_rsp = 1'b1;
        rsp_cyc = c;
        rd      = bus.rsp_rdata;
        err     = bus.rsp_error;
        break;
      end
    end
    bus.mem_ack = 1'b0;
    check($sformatf("v%0d rsp_seen", idx), 32'(got_rsp), 32'd1);
    check($sformatf("v%0d mem_cycles", idx), 32'(mem_cycles),
          v.exp_access ? 32'(v.ack_delay + 1) : 32'd0);
    if (v.exp_access)
      check($sformatf("v%0d latency", idx), 32'(rsp_cyc), 32'(v.ack_delay + 2));
    else
      check($sformatf("v%0d latency_le2", idx), 32'(rsp_cyc >= 1 && rsp_cyc <= 2), 32'd1);
    check($sformatf("v%0d rsp_rdata", idx), rd, v.exp_rdata);
    check($sformatf("v%0d rsp_error", idx), 32'(err), 32'(v.exp_err));
    @(negedge clk);
    check($sformatf("v%0d rsp_pulse", idx), 32'(bus.rsp_valid), 32'd0);
    check($sformatf("v%0d ready_back", idx), 32'(bus.req_ready), 32'd1);
  endtask

  initial begin
    logic seen_bad;
    int   mem_cnt;
    logic got_rsp;
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rdata  = '0;

    //           wr    f3      addr          wdata         rdata         dly acc exp_addr      be       exp_wdata     exp_rdata     err
    vq.push_back('{1'b0, 3'b010, 32'h0000_00a8, 32'h0,        32'hdeadbeef, 2,  1'b1, 32'h0000_00a8, 4'b1111, 32'h0,        32'hdeadbeef, 1'b0});
    vq.push_back('{1'b0, 3'b000, 32'h0000_00ab, 32'h0,        32'hdeadbeef, 0,  1'b1, 32'h0000_00a8, 4'b1000, 32'h0,        32'hffffffde, 1'b0});
    vq.push_back('{1'b0, 3'b101, 32'h0000_00a2, 32'h0,        32'hcafebabe, 1,  1'b1, 32'h0000_00a0, 4'b1100, 32'h0,        32'h0000cafe, 1'b0});
    vq.push_back('{1'b1, 3'b000, 32'h0000_00a1, 32'h0000_00ab, 32'h11111111, 0,  1'b1, 32'h0000_00a0, 4'b0010, 32'habababab, 32'h0,        1'b0});
    vq.push_back('{1'b0, 3'b100, 32'h0000_0013, 32'h0,        32'h80ff7f01, 0,  1'b1, 32'h0000_0010, 4'b1000, 32'h0,        32'h00000080, 1'b0});
    vq.push_back('{1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h1234f00d, 3,  1'b1, 32'h0000_0100, 4'b0011, 32'h0,        32'hfffff00d, 1'b0});
    vq.push_back('{1'b0, 3'b000, 32'h0000_0041, 32'h0,        32'h00007f80, 0,  1'b1, 32'h0000_0040, 4'b0010, 32'h0,        32'h0000007f, 1'b0});
    vq.push_back('{1'b1, 3'b001, 32'h0000_0202, 32'hffff1234, 32'h22222222, 1,  1'b1, 32'h0000_0200, 4'b1100, 32'h12341234, 32'h0,        1'b0});
    vq.push_back('{1'b1, 3'b010, 32'h0000_003c, 32'h01020304, 32'h33333333, 0,  1'b1, 32'h0000_003c, 4'b1111, 32'h01020304, 32'h0,        1'b0});
    vq.push_back('{1'b0, 3'b011, 32'h0000_0050, 32'h0,        32'h44444444, 0,  1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1});
    vq.push_back('{1'b1, 3'b110, 32'h0000_0054, 32'h89abcdef, 32'h55555555, 0,  1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1});
`ifdef LSU_MISALIGN_TRAP_EN
    vq.push_back('{1'b0, 3'b010, 32'h0000_00a2, 32'h0,        32'h55aa33cc, 0,  1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1});
    vq.push_back('{1'b0, 3'b001, 32'h0000_0045, 32'h0,        32'h12348001, 0,  1'b0, 32'h0,        4'b0000, 32'h0,        32'h0,        1'b1});
`else
    vq.push_back('{1'b0, 3'b010, 32'h0000_00a2, 32'h0,        32'h55aa33cc, 0,  1'b1, 32'h0000_00a0, 4'b1111, 32'h0,        32'h55aa33cc, 1'b0});
    vq.push_back('{1'b0, 3'b001, 32'h0000_0045, 32'h0,        32'h12348001, 1,  1'b1, 32'h0000_0044, 4'b0011, 32'h0,        32'hffff8001, 1'b0});
`endif
    vq.push_back('{1'b0, 3'b000, 32'h0000_0002, 32'h0,        32'h00ab0000, 15, 1'b1, 32'h0000_0000, 4'b0100, 32'h0,        32'hffffffab, 1'b0});
    vq.push_back('{1'b1, 3'b000, 32'h0000_0003, 32'hffffff5a, 32'h66666666, 2,  1'b1, 32'h0000_0000, 4'b1000, 32'h5a5a5a5a, 32'h0,        1'b0});

    // Reset state
    repeat (2) @(negedge clk);
    check("rst req_ready", 32'(bus.req_ready), 32'd1);
    check("rst mem_req",   32'(bus.mem_req),   32'd0);
    check("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst outputs",   bus.rsp_rdata | bus.mem_addr | bus.mem_wdata
                           | 32'(bus.mem_be) | 32'(bus.mem_we) | 32'(bus.rsp_error), 32'd0);
    reset = 1'b1;

    for (int i = 0; i < vq.size(); i++) run_vec(i, vq[i]);

    // mem_ack while idle must not produce a response
    @(negedge clk);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0badf00d;
    seen_bad = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.mem_req || !bus.req_ready) seen_bad = 1'b1;
    end
    bus.mem_ack = 1'b0;
    check("idle_ack ignored", 32'(seen_bad), 32'd0);

    // Timeout: no mem_ack at all
    @(negedge clk);
    drive_req(1'b0, 3'b010, 32'h0000_0080, 32'h0);
    @(posedge clk);
    mem_cnt = 0;
    got_rsp = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.mem_req) mem_cnt++;
      if (bus.rsp_valid) begin
        got_rsp = 1'b1;
        check("tmo mem_req_low", 32'(bus.mem_req), 32'd0);
        check("tmo rsp_error", 32'(bus.rsp_error), 32'd1);
        check("tmo rsp_rdata", bus.rsp_rdata, 32'd0);
        check("tmo latency", 32'(c), 32'd17);
        break;
      end
    end
    check("tmo rsp_seen", 32'(got_rsp), 32'd1);
    check("tmo mem_cycles", 32'(mem_cnt), 32'd16);

    // Reset pulled low mid-ACCESS abandons the access
    @(negedge clk);
    drive_req(1'b0, 3'b010, 32'h0000_0090, 32'h0);
    @(posedge clk);
    repeat (3) @(negedge clk);
    bus.req_valid = 1'b0;
    check("rstmid mem_req_before", 32'(bus.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    check("rstmid mem_req", 32'(bus.mem_req), 32'd0);
    check("rstmid req_ready", 32'(bus.req_ready), 32'd1);
    check("rstmid rsp_valid", 32'(bus.rsp_valid), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    seen_bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid || bus.mem_req) seen_bad = 1'b1;
    end
    check("rstmid no_response", 32'(seen_bad), 32'd0);

    // Normal operation after the abandoned access
    run_vec(99, vq[0]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
